// File: rtl/avaloon_cmps_ram_pkg.sv
// Shared types and constants for the avaloon_cmps dual-port on-chip RAM.
package avaloon_cmps_ram_pkg;

  // Controller states: hold in reset, zero-fill the array, serve requests.
  typedef enum logic [1:0] {
    RESET_ST = 2'd0,
    CLEAR    = 2'd1,
    READY    = 2'd2
  } ram_state_e;

  // Supported read latencies: 1 = array read register only, 2 = extra output register.
  localparam int unsigned RD_LATENCY_MIN = 1;
  localparam int unsigned RD_LATENCY_MAX = 2;

  // Same-address, same-cycle write collision: when set, the s1 write is kept.
  localparam bit S1_WINS = 1'b1;

  // Out-of-range latency requests are pulled to the nearest legal value.
  function automatic int unsigned rd_latency_clamp(input int unsigned lat);
    if (lat < RD_LATENCY_MIN) return RD_LATENCY_MIN;
    if (lat > RD_LATENCY_MAX) return RD_LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/avaloon_cmps_ram_rdpipe.sv
// Per-port read-return pipeline: valid/data shift register of LATENCY stages.
// Stages advance only on enabled cycles; asynchronous reset flushes everything.
module avaloon_cmps_ram_rdpipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q [LATENCY];
  logic [DATA_W-1:0] data_q  [LATENCY];

  // Shift one stage per enabled cycle; hold everything while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
      end
    end else if (en_i) begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        valid_q[k] <= valid_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  // A result parked in the last stage while disabled is masked, so each read
  // yields exactly one enabled cycle with valid high.
  assign valid_o = valid_q[LATENCY-1] & en_i;
  assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/avaloon_cmps_dpram.sv
// Parametrised dual-port Avalon-MM on-chip RAM with byte enables, selectable
// read latency, post-reset zero-fill sequencer and sticky out-of-range flag.
module avaloon_cmps_dpram
  import avaloon_cmps_ram_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 5120,
  parameter int unsigned ADDR_W         = 13,
  parameter int unsigned RD_LATENCY     = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                reset_req,
  output logic                busy,
  output logic                oor_err,

  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,

  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned LAT   = rd_latency_clamp(RD_LATENCY);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  ram_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              oor_q, oor_d;

  logic en, ready;
  logic s1_acc, s1_we, s1_re, s1_in, s1_wr_en;
  logic s2_acc, s2_we, s2_re, s2_in, s2_wr_en;
  logic collide, clr_we;

  logic              p1_we;
  logic [IDX_W-1:0]  p1_idx;
  logic [DATA_W-1:0] p1_data;
  logic [NB-1:0]     p1_be;

  logic [DATA_W-1:0] s1_rd_raw, s2_rd_raw;

  assign en    = clken & ~reset_req;
  assign ready = (state_q == READY);

  // Request qualification per port; a combined read+write performs the write only.
  always_comb begin
    s1_acc = ready & en & s1_chipselect & (s1_read | s1_write);
    s2_acc = ready & en & s2_chipselect & (s2_read | s2_write);
    s1_we  = s1_acc & s1_write;
    s2_we  = s2_acc & s2_write;
    s1_re  = s1_acc & s1_read & ~s1_write;
    s2_re  = s2_acc & s2_read & ~s2_write;
    s1_in  = 32'(s1_address) < DEPTH;
    s2_in  = 32'(s2_address) < DEPTH;
  end

  // Write arbitration: out-of-range writes vanish, same-address writes keep one side.
  always_comb begin
    collide  = s1_we & s1_in & s2_we & s2_in & (s1_address == s2_address);
    s1_wr_en = s1_we & s1_in & ~(collide & ~S1_WINS);
    s2_wr_en = s2_we & s2_in & ~(collide &  S1_WINS);
    clr_we   = (state_q == CLEAR) & en;
  end

  // Port 1 carries either the clear sequencer or the s1 master (never both).
  always_comb begin
    p1_we   = clr_we | s1_wr_en;
    p1_idx  = clr_we ? clr_cnt_q[IDX_W-1:0] : s1_address[IDX_W-1:0];
    p1_data = clr_we ? '0 : s1_writedata;
    p1_be   = clr_we ? '1 : s1_byteenable;
  end

  // Array write ports with per-lane byte enables.
  always_ff @(posedge clk) begin
    if (p1_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (p1_be[b]) mem[p1_idx][b*8 +: 8] <= p1_data[b*8 +: 8];
      end
    end
    if (s2_wr_en) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (s2_byteenable[b]) mem[s2_address[IDX_W-1:0]][b*8 +: 8] <= s2_writedata[b*8 +: 8];
      end
    end
  end

  // Array read; the pipeline's first stage samples this at the accept edge,
  // before any same-edge write lands, giving read-before-write.
  always_comb begin
    s1_rd_raw = s1_in ? mem[s1_address[IDX_W-1:0]] : '0;
    s2_rd_raw = s2_in ? mem[s2_address[IDX_W-1:0]] : '0;
  end

  // Next state for the controller, clear counter and sticky out-of-range flag.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    oor_d     = oor_q | (s1_acc & ~s1_in) | (s2_acc & ~s2_in);
    case (state_q)
      RESET_ST: begin
        state_d   = CLEAR_ON_RESET ? CLEAR : READY;
        clr_cnt_d = '0;
      end
      CLEAR: begin
        if (en) begin
          if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d   = READY;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
      end
      READY:   state_d = READY;
      default: state_d = RESET_ST;
    endcase
  end

  // Controller registers; reset restarts the clear from address 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RESET_ST;
      clr_cnt_q <= '0;
      oor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      oor_q     <= oor_d;
    end
  end

  assign busy           = (state_q == CLEAR) | ((state_q == RESET_ST) & CLEAR_ON_RESET);
  assign oor_err        = oor_q;
  assign s1_waitrequest = ~(ready & en);
  assign s2_waitrequest = ~(ready & en);

  avaloon_cmps_ram_rdpipe #(
    .DATA_W (DATA_W),
    .LATENCY(LAT)
  ) u_rdpipe_s1 (
    .clk    (clk),
    .rst    (reset),
    .en_i   (en),
    .valid_i(s1_re),
    .data_i (s1_rd_raw),
    .valid_o(s1_readdatavalid),
    .data_o (s1_readdata)
  );

  avaloon_cmps_ram_rdpipe #(
    .DATA_W (DATA_W),
    .LATENCY(LAT)
  ) u_rdpipe_s2 (
    .clk    (clk),
    .rst    (reset),
    .en_i   (en),
    .valid_i(s2_re),
    .data_i (s2_rd_raw),
    .valid_o(s2_readdatavalid),
    .data_o (s2_readdata)
  );

endmodule
